// File: rtl/mips_pkg.sv
// Shared MIPS multicycle control types: FSM state encoding, opcode/funct fields, ALU op codes.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from aluop and funct; purely combinational, no state, no backpressure.
module alu_decoder
  import mips_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// MIPS multicycle control FSM: 2-5 cycles per instruction, no backpressure; pcen/alucontrol combinational.
// Optional BNE_EN macro adds bne support through the BRANCH state.
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pcen,
  output logic        irwrite,
  output logic        regwrite,
  output logic        memwrite,
  output logic        iord,
  output logic        alusrca,
  output logic        memtoreg,
  output logic        regdst,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [2:0]  alucontrol
);

  state_t state, state_nxt, dec_state;
  aluop_t aluop;
  logic   pcwrite, branch, take;
  logic   irwrite_s, regwrite_s, memwrite_s;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH: state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXECUTE;
          OP_BEQ:       state_nxt = BRANCH;
`ifdef BNE_EN
          OP_BNE:       state_nxt = BRANCH;
`endif
          OP_ADDI:      state_nxt = ADDIEXEC;
          OP_J:         state_nxt = JUMP;
          default:      state_nxt = FETCH;
        endcase
      end
      MEMADR:   state_nxt = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    state_nxt = MEMWB;
      EXECUTE:  state_nxt = ALUWB;
      ADDIEXEC: state_nxt = ADDIWB;
      default:  state_nxt = FETCH;
    endcase
  end

  // Outputs decode FETCH while reset is held so the datapath sees a clean fetch setup.
  assign dec_state = reset ? FETCH : state;

  always_comb begin
    pcwrite    = 1'b0;
    branch     = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = ALUOP_ADD;
    case (dec_state)
      FETCH: begin
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
        alusrcb   = 2'b01;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR, ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        regwrite_s = 1'b1;
        regdst     = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIWB: regwrite_s = 1'b1;
      JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      default: ;
    endcase
  end

`ifdef BNE_EN
  assign take = branch & (((op == OP_BEQ) & zero) | ((op == OP_BNE) & ~zero));
`else
  assign take = branch & zero;
`endif

  assign pcen     = ~reset & (pcwrite | take);
  assign irwrite  = ~reset & irwrite_s;
  assign regwrite = ~reset & regwrite_s;
  assign memwrite = ~reset & memwrite_s;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and full output vector against hand-built tables.
module tb_multicycle_ctrl;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic zero = 1'b0;
  logic pcen, irwrite, regwrite, memwrite, iord, alusrca, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [14:0] obs;
  int tests = 0;
  int fails = 0;

  // {pcen,irwrite,regwrite,memwrite,iord,alusrca,memtoreg,regdst, alusrcb, pcsrc, alucontrol}
  localparam logic [14:0] O_RST     = 15'b00000000_01_00_010;
  localparam logic [14:0] O_FETCH   = 15'b11000000_01_00_010;
  localparam logic [14:0] O_DECODE  = 15'b00000000_11_00_010;
  localparam logic [14:0] O_MEMADR  = 15'b00000100_10_00_010;
  localparam logic [14:0] O_MEMRD   = 15'b00001000_00_00_010;
  localparam logic [14:0] O_MEMWB   = 15'b00100010_00_00_010;
  localparam logic [14:0] O_MEMWR   = 15'b00011000_00_00_010;
  localparam logic [14:0] O_EXSLT   = 15'b00000100_00_00_111;
  localparam logic [14:0] O_ALUWB   = 15'b00100001_00_00_010;
  localparam logic [14:0] O_BR_T    = 15'b10000100_00_01_110;
  localparam logic [14:0] O_BR_N    = 15'b00000100_00_01_110;
  localparam logic [14:0] O_ADDIWB  = 15'b00100000_00_00_010;
  localparam logic [14:0] O_JUMP    = 15'b10000000_00_10_010;

  assign obs = {pcen, irwrite, regwrite, memwrite, iord, alusrca, memtoreg, regdst,
                alusrcb, pcsrc, alucontrol};

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
    .iord(iord), .alusrca(alusrca), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if (dut.state !== FETCH || obs !== O_RST) begin
      fails++;
      $display("FAIL reset_hold: state=%0d outs=%b want state=%0d outs=%b", dut.state, obs, FETCH, O_RST);
    end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    state_t es [5] = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
    logic [14:0] eo [5] = '{O_FETCH, O_DECODE, O_MEMADR, O_MEMRD, O_MEMWB};
    op = OP_LW; funct = 6'd0; zero = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      tests++;
      if (dut.state !== es[c] || obs !== eo[c]) begin
        fails++;
        $display("FAIL lw_cyc%0d: state=%0d outs=%b want state=%0d outs=%b", c + 1, dut.state, obs, es[c], eo[c]);
      end
    end
    @(negedge clk); #1;
    tests++;
    if (dut.state !== FETCH) begin fails++; $display("FAIL lw_done: state=%0d want %0d", dut.state, FETCH); end
  endtask

  task automatic test_sw();
    state_t es [4] = '{FETCH, DECODE, MEMADR, MEMWR};
    logic [14:0] eo [4] = '{O_FETCH, O_DECODE, O_MEMADR, O_MEMWR};
    op = OP_SW; funct = 6'd0; zero = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      tests++;
      if (dut.state !== es[c] || obs !== eo[c]) begin
        fails++;
        $display("FAIL sw_cyc%0d: state=%0d outs=%b want state=%0d outs=%b", c + 1, dut.state, obs, es[c], eo[c]);
      end
    end
    @(negedge clk); #1;
    tests++;
    if (dut.state !== FETCH) begin fails++; $display("FAIL sw_done: state=%0d want %0d", dut.state, FETCH); end
  endtask

  task automatic test_rtype_slt();
    state_t es [4] = '{FETCH, DECODE, EXECUTE, ALUWB};
    logic [14:0] eo [4] = '{O_FETCH, O_DECODE, O_EXSLT, O_ALUWB};
    op = OP_RTYPE; funct = F_SLT; zero = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      tests++;
      if (dut.state !== es[c] || obs !== eo[c]) begin
        fails++;
        $display("FAIL slt_cyc%0d: state=%0d outs=%b want state=%0d outs=%b", c + 1, dut.state, obs, es[c], eo[c]);
      end
    end
    @(negedge clk); #1;
    tests++;
    if (dut.state !== FETCH) begin fails++; $display("FAIL slt_done: state=%0d want %0d", dut.state, FETCH); end
  endtask

  task automatic test_alu_funct();
    logic [5:0] fs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000111};
    logic [2:0] ac [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b010};
    op = OP_RTYPE; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      funct = fs[i];
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if (dut.state !== EXECUTE || alucontrol !== ac[i]) begin
        fails++;
        $display("FAIL funct_%b: state=%0d alucontrol=%b want state=%0d alucontrol=%b", fs[i], dut.state, alucontrol, EXECUTE, ac[i]);
      end
      repeat (2) @(negedge clk);
    end
    #1;
    tests++;
    if (dut.state !== FETCH) begin fails++; $display("FAIL funct_done: state=%0d want %0d", dut.state, FETCH); end
  endtask

  task automatic test_beq();
    op = OP_BEQ; funct = 6'd0;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      #1;
      tests++;
      if (dut.state !== FETCH || obs !== O_FETCH) begin
        fails++;
        $display("FAIL beq%0d_fetch: state=%0d outs=%b want state=%0d outs=%b", z, dut.state, obs, FETCH, O_FETCH);
      end
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if (dut.state !== BRANCH || obs !== (z == 1 ? O_BR_T : O_BR_N)) begin
        fails++;
        $display("FAIL beq%0d_branch: state=%0d outs=%b want state=%0d outs=%b", z, dut.state, obs, BRANCH,
                 (z == 1 ? O_BR_T : O_BR_N));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_addi();
    state_t es [4] = '{FETCH, DECODE, ADDIEXEC, ADDIWB};
    logic [14:0] eo [4] = '{O_FETCH, O_DECODE, O_MEMADR, O_ADDIWB};
    op = OP_ADDI; funct = F_SUB; zero = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      tests++;
      if (dut.state !== es[c] || obs !== eo[c]) begin
        fails++;
        $display("FAIL addi_cyc%0d: state=%0d outs=%b want state=%0d outs=%b", c + 1, dut.state, obs, es[c], eo[c]);
      end
    end
    @(negedge clk); #1;
    tests++;
    if (dut.state !== FETCH) begin fails++; $display("FAIL addi_done: state=%0d want %0d", dut.state, FETCH); end
  endtask

  task automatic test_jump();
    op = OP_J; funct = 6'd0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (dut.state !== JUMP || obs !== O_JUMP) begin
      fails++;
      $display("FAIL j_cyc3: state=%0d outs=%b want state=%0d outs=%b", dut.state, obs, JUMP, O_JUMP);
    end
    @(negedge clk); #1;
    tests++;
    if (dut.state !== FETCH) begin fails++; $display("FAIL j_done: state=%0d want %0d", dut.state, FETCH); end
  endtask

  task automatic test_illegal();
    op = 6'b111111; funct = 6'd0; zero = 1'b1;
    @(negedge clk); #1;
    tests++;
    if (dut.state !== DECODE || obs !== O_DECODE) begin
      fails++;
      $display("FAIL illegal_decode: state=%0d outs=%b want state=%0d outs=%b", dut.state, obs, DECODE, O_DECODE);
    end
    @(negedge clk); #1;
    tests++;
    if (dut.state !== FETCH || obs !== O_FETCH) begin
      fails++;
      $display("FAIL illegal_refetch: state=%0d outs=%b want state=%0d outs=%b", dut.state, obs, FETCH, O_FETCH);
    end
  endtask

  task automatic test_bne();
    op = OP_BNE; funct = 6'd0; zero = 1'b0;
    @(negedge clk); #1;
    tests++;
    if (pcen !== 1'b0) begin fails++; $display("FAIL bne_decode_pcen: pcen=%b want 0", pcen); end
    @(negedge clk); #1;
`ifdef BNE_EN
    tests++;
    if (dut.state !== BRANCH || obs !== O_BR_T) begin
      fails++;
      $display("FAIL bne_branch: state=%0d outs=%b want state=%0d outs=%b", dut.state, obs, BRANCH, O_BR_T);
    end
    zero = 1'b1; #1;
    tests++;
    if (pcen !== 1'b0) begin fails++; $display("FAIL bne_zero1_pcen: pcen=%b want 0", pcen); end
    @(negedge clk); #1;
`endif
    tests++;
    if (dut.state !== FETCH) begin fails++; $display("FAIL bne_done: state=%0d want %0d", dut.state, FETCH); end
  endtask

  task automatic test_reset_mid();
    op = OP_SW; funct = 6'd0; zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (dut.state !== MEMWR || memwrite !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pre: state=%0d memwrite=%b want state=%0d memwrite=1", dut.state, memwrite, MEMWR);
    end
    reset = 1'b1; #1;
    tests++;
    if (obs !== O_RST) begin fails++; $display("FAIL rstmid_outs: outs=%b want %b", obs, O_RST); end
    @(negedge clk); #1;
    tests++;
    if (dut.state !== FETCH || obs !== O_RST) begin
      fails++;
      $display("FAIL rstmid_state: state=%0d outs=%b want state=%0d outs=%b", dut.state, obs, FETCH, O_RST);
    end
    reset = 1'b0; op = 6'b111111; #1;
    tests++;
    if (obs !== O_FETCH) begin fails++; $display("FAIL rstmid_release: outs=%b want %b", obs, O_FETCH); end
    @(negedge clk); #1;
    tests++;
    if (dut.state !== DECODE) begin fails++; $display("FAIL rstmid_decode: state=%0d want %0d", dut.state, DECODE); end
    @(negedge clk); #1;
    tests++;
    if (dut.state !== FETCH) begin fails++; $display("FAIL rstmid_done: state=%0d want %0d", dut.state, FETCH); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype_slt();
    test_alu_funct();
    test_beq();
    test_addi();
    test_jump();
    test_illegal();
    test_bne();
    test_lw();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 No parameters; all widths SHALL be fixed by the MIPS multicycle datapath.
REQ-002 clk  input  1  single system clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  instruction[31:26] from the instruction register.
REQ-005 funct  input  6  instruction[5:0] from the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 pcen, irwrite, regwrite, memwrite  output  1 each  write enables for PC, IR, register file and memory.
REQ-008 iord, alusrca, memtoreg, regdst  output  1 each  datapath mux selects.
REQ-009 alusrcb  output  2  ALU B-source select: 00 reg, 01 const 4, 10 signimm, 11 signimm<<2.
REQ-010 pcsrc  output  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 alucontrol  output  3  ALU operation.

Function
REQ-012 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB and JUMP; the block SHALL be a Moore FSM, except that pcen and alucontrol are combinational.
REQ-013 Transitions:
- FETCH->DECODE.
- DECODE by op: lw 100011 / sw 101011 -> MEMADR; R-type 000000 -> EXECUTE; beq 000100 -> BRANCH; addi 001000 -> ADDIEXEC; j 000010 -> JUMP; any other op -> FETCH.
- MEMADR: ->MEMRD for lw, ->MEMWR for sw.
- MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEXEC->ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
REQ-014 Per-state outputs; every output not listed SHALL be 0 and aluop SHALL be 00:
- FETCH: irwrite=1, pcwrite=1, alusrcb=01.
- DECODE: alusrcb=11.
- MEMADR / ADDIEXEC: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: regwrite=1, memtoreg=1.
- MEMWR: iord=1, memwrite=1.
- EXECUTE: alusrca=1, aluop=10.
- ALUWB: regwrite=1, regdst=1.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIWB: regwrite=1.
- JUMP: pcwrite=1, pcsrc=10.
REQ-015 pcen SHALL equal pcwrite | (branch & zero), evaluated in the current cycle.
REQ-016 alucontrol mapping:
- aluop 00 -> 010.
- aluop 01 -> 110.
- aluop 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; any other funct -> 010.
REQ-017 Latency in cycles from FETCH: lw 5; sw, R-type and addi 4; beq and j 3; illegal op 2.

Reset
REQ-018 A cycle with reset high SHALL load FETCH, regardless of the current state (including mid-instruction).
REQ-019 While reset is high, pcen, irwrite, regwrite and memwrite SHALL be forced to 0; all other outputs SHALL follow the FETCH decode.
REQ-020 After reset deasserts, the first rising edge SHALL perform a normal FETCH.

Configuration
REQ-021 Macro BNE_EN defined: op 000101 (bne) SHALL go DECODE->BRANCH; in BRANCH, pcen SHALL equal (beq & zero) | (bne & ~zero).
REQ-022 Macro BNE_EN undefined: op 000101 SHALL be treated as illegal (DECODE->FETCH), and there SHALL be no bne logic.

Structure
REQ-023 The shared package mips_pkg SHALL hold:
- the state enum typedef (4-bit);
- opcode constants (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J);
- the aluop typedef;
- funct constants.
REQ-024 The alucontrol decode SHALL be the sub-module alu_decoder (aluop, funct -> alucontrol); the FSM and output decode SHALL live in multicycle_ctrl.

Verification
REQ-025 lw: reset, then op=100011 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 with memtoreg=1 in cycle 5 only; memwrite never 1.
REQ-026 R-type slt: op=000000, funct=101010 -> alucontrol=111 in EXECUTE; regwrite=1 with regdst=1 in cycle 4.
REQ-027 beq: op=000100 with zero=1 -> pcen=1, pcsrc=01 in cycle 3; with zero=0 -> pcen=0 in cycle 3.
REQ-028 Illegal op=111111 -> DECODE->FETCH; no regwrite or memwrite asserted; the next FETCH is in cycle 3.
REQ-029 Reset asserted during MEMWR -> memwrite=0 in that cycle, state=FETCH on the next edge.
REQ-030 bne (op=000101, zero=0): with BNE_EN -> pcen=1 in BRANCH; without BNE_EN -> DECODE->FETCH and pcen=0.
